// File: rtl/unified_mem_arbiter.sv
// Arbiter that lets the fetch and data ports share one fixed-latency memory.
// Data has priority over fetch, and each access holds the memory for MEM_LATENCY cycles.
module unified_mem_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] LAT = CW'(MEM_LATENCY);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_valid_q, if_valid_d;
    logic              d_valid_q, d_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              cancel_q, cancel_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_valid_d = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        cancel_d    = cancel_q;
        case (state_q)
            IDLE: begin
                cancel_d = 1'b0;
                // A port still showing its valid pulse is skipped so a held request is not re-issued.
                if (d_req && !d_valid_q) begin
                    state_d     = BUSY_D;
                    cnt_d       = LAT;
                    mem_valid_d = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (if_req && !if_valid_q && !if_flush) begin
                    state_d     = BUSY_I;
                    cnt_d       = LAT;
                    mem_valid_d = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                end
            end
            BUSY_I: begin
                cnt_d = cnt_q - CW'(1);
                if (if_flush) cancel_d = 1'b1;
                if (cnt_q == CW'(1)) begin
                    // A redirected fetch still occupies the memory but its result is dropped.
                    if (!cancel_q && !if_flush) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                    state_d  = IDLE;
                    cancel_d = 1'b0;
                end
            end
            BUSY_D: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    d_valid_d = 1'b1;
                    if (!mem_we_q) d_rdata_d = mem_rdata;
                    mem_we_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            cancel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            cancel_q    <= cancel_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_stall  = if_req & ~if_valid_q;
    assign d_stall   = d_req & ~d_valid_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: drivers push expected memory issues and
// responses with their cycle stamps; a negedge monitor pops and compares them.
module tb_unified_mem_arbiter;
    localparam int L  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [DW-1:0] JUNK = 32'hBADBAD00;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_flush, if_valid, if_stall;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_valid, d_stall;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_valid, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    unified_mem_arbiter #(.MEM_LATENCY(L), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] if_exp_q[$];
    int            if_cyc_q[$];
    logic [DW-1:0] d_exp_q[$];
    int            d_cyc_q[$];
    logic [64:0]   mem_exp_q[$];
    int            mem_cyc_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected pulse, got 1 expected 0 (cycle %0d)", name, cyc);
    endtask

    // ---------------- memory model ----------------
    logic [DW-1:0] mem [logic [AW-1:0]];
    int            mcnt = 0;
    logic [AW-1:0] maddr;

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            mcnt      = 0;
            mem_rdata = JUNK;
        end else if (mem_valid) begin
            mcnt  = L;
            maddr = mem_addr;
            if (mem_we) mem[mem_addr] = mem_wdata;
            mem_rdata = (mcnt == 1) ? rd(maddr) : JUNK;
        end else if (mcnt > 0) begin
            mcnt--;
            mem_rdata = (mcnt == 1) ? rd(maddr) : JUNK;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_valid) begin
                if (mem_exp_q.size() == 0) unexpected("mem_valid");
                else begin
                    logic [64:0] e;
                    int          c;
                    e = mem_exp_q.pop_front();
                    c = mem_cyc_q.pop_front();
                    chk("mem_we", 64'(mem_we), 64'(e[64]));
                    chk("mem_addr", 64'(mem_addr), 64'(e[63:32]));
                    if (e[64]) chk("mem_wdata", 64'(mem_wdata), 64'(e[31:0]));
                    chk("mem_issue_cycle", 64'(cyc), 64'(c));
                end
            end
            if (if_valid) begin
                if (if_exp_q.size() == 0) unexpected("if_valid");
                else begin
                    chk("if_rdata", 64'(if_rdata), 64'(if_exp_q.pop_front()));
                    chk("if_valid_cycle", 64'(cyc), 64'(if_cyc_q.pop_front()));
                end
            end
            if (d_valid) begin
                if (d_exp_q.size() == 0) unexpected("d_valid");
                else begin
                    chk("d_rdata", 64'(d_rdata), 64'(d_exp_q.pop_front()));
                    chk("d_valid_cycle", 64'(cyc), 64'(d_cyc_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic exp_mem(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd, input int c);
        mem_exp_q.push_back({we, a, wd});
        mem_cyc_q.push_back(c);
    endtask

    task automatic exp_if(input logic [DW-1:0] v, input int c);
        if_exp_q.push_back(v);
        if_cyc_q.push_back(c);
    endtask

    task automatic exp_d(input logic [DW-1:0] v, input int c);
        d_exp_q.push_back(v);
        d_cyc_q.push_back(c);
    endtask

    task automatic wait_if_valid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_valid && n < 40);
        if (!if_valid) chk({name, "_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic wait_d_valid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_valid && n < 40);
        if (!d_valid) chk({name, "_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic plain_fetch(input logic [AW-1:0] a, input string name);
        int g;
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = a;
        g = cyc + 1;
        exp_mem(1'b0, a, '0, g);
        exp_if(rd(a), g + L);
        #1;
        chk({name, "_stall_hi"}, 64'(if_stall), 64'(1));
        wait_if_valid(name);
        chk({name, "_stall_lo"}, 64'(if_stall), 64'(0));
        if_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int g;
        mem[32'h100]  = 32'h00500093;
        mem[32'h104]  = 32'h00A00113;
        mem[32'h180]  = 32'h11111111;
        mem[32'h200]  = 32'h22222222;
        mem[32'h2000] = 32'hDEADBEEF;
        mem[32'h3000] = 32'h33333333;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_valid", 64'(mem_valid), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_if_valid", 64'(if_valid), 64'(0));
        chk("rst_d_rdata", 64'(d_rdata), 64'(0));
        reset = 1'b0;

        // Single fetch from reset.
        plain_fetch(32'h100, "fetch1");

        // Simultaneous requests: data first, fetch in the next idle cycle.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        g = cyc + 1;
        exp_mem(1'b0, 32'h2000, '0, g);
        exp_d(32'hDEADBEEF, g + L);
        exp_mem(1'b0, 32'h104, '0, g + L + 1);
        exp_if(32'h00A00113, g + 2 * L + 1);
        wait_d_valid("both_d");
        chk("both_if_stall", 64'(if_stall), 64'(1));
        d_req = 1'b0;
        wait_if_valid("both_if");
        if_req = 1'b0;

        // Store: d_rdata keeps the previous load value.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'h12345678;
        g = cyc + 1;
        exp_mem(1'b1, 32'h2004, 32'h12345678, g);
        exp_d(32'hDEADBEEF, g + L);
        wait_d_valid("store");
        d_req = 1'b0; d_we = 1'b0;

        // Load back the stored word, changing the address mid-transaction.
        @(negedge clk);
        d_req = 1'b1; d_addr = 32'h2004;
        g = cyc + 1;
        exp_mem(1'b0, 32'h2004, '0, g);
        exp_d(32'h12345678, g + L);
        @(negedge clk);
        d_addr = 32'h2000;
        wait_d_valid("load_back");
        d_req = 1'b0;

        // Flush during BUSY cycle 2 suppresses the fetch; a new fetch then completes.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h180;
        g = cyc + 1;
        exp_mem(1'b0, 32'h180, '0, g);
        @(negedge clk);
        @(negedge clk);
        if_flush = 1'b1; if_req = 1'b0;
        @(negedge clk);
        if_flush = 1'b0; if_req = 1'b1; if_addr = 32'h200;
        exp_mem(1'b0, 32'h200, '0, g + L + 1);
        exp_if(32'h22222222, g + 2 * L + 1);
        wait_if_valid("flush_refetch");
        if_req = 1'b0;

        // Reset in cycle 2 of a load: everything clears, no response.
        @(negedge clk);
        d_req = 1'b1; d_addr = 32'h3000;
        g = cyc + 1;
        exp_mem(1'b0, 32'h3000, '0, g);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; d_req = 1'b0;
        #1;
        chk("arst_mem_valid", 64'(mem_valid), 64'(0));
        chk("arst_mem_addr", 64'(mem_addr), 64'(0));
        chk("arst_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("arst_if_rdata", 64'(if_rdata), 64'(0));
        chk("arst_d_rdata", 64'(d_rdata), 64'(0));
        chk("arst_d_valid", 64'(d_valid), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        plain_fetch(32'h100, "post_reset_fetch");

        // Held data request during the valid cycle: exactly one memory issue.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        g = cyc + 1;
        exp_mem(1'b0, 32'h2000, '0, g);
        exp_d(32'hDEADBEEF, g + L);
        wait_d_valid("held");
        @(negedge clk);
        chk("held_no_regrant", 64'(mem_valid), 64'(0));
        chk("held_d_stall", 64'(d_stall), 64'(1));
        d_req = 1'b0;
        repeat (8) @(negedge clk);

        chk("mem_q_empty", 64'(mem_exp_q.size()), 64'(0));
        chk("if_q_empty", 64'(if_exp_q.size()), 64'(0));
        chk("d_q_empty", 64'(d_exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch (IF) port and data (MEM-stage) port.
- Sequences each access through a small FSM and returns read data or write completion to the requester.
- Generates per-port stall signals that feed the pipeline's hazard/stall logic. Stalls are consumed alongside the control unit's isStall input.

Parameters:
MEM_LATENCY, 4, cycles from memory issue (mem_valid high) to mem_rdata valid; legal range 1..15
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
if_req  input  1  fetch request; held stable until if_valid
if_addr  input  ADDR_W  fetch address
if_flush  input  1  cancel pending/in-flight fetch (branch redirect)
if_valid  output  1  one-cycle pulse: if_rdata holds fetched instruction
if_rdata  output  DATA_W  fetched instruction
if_stall  output  1  fetch not yet satisfied
d_req  input  1  data request (load or store); held stable until d_valid
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_valid  output  1  one-cycle pulse: load data ready / store complete
d_rdata  output  DATA_W  load data
d_stall  output  1  data access not yet satisfied
mem_valid  output  1  one-cycle issue strobe to memory
mem_we  output  1  memory write enable, qualified by mem_valid
mem_addr  output  ADDR_W  memory address, registered
mem_wdata  output  DATA_W  memory write data, registered
mem_rdata  input  DATA_W  memory read data, valid MEM_LATENCY cycles after issue

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D. Latency counter is $clog2(MEM_LATENCY+1) bits.
- Reset values: state=IDLE, counter=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, if_valid=0, d_valid=0, if_rdata=0, d_rdata=0, cancel flag=0.
- Grant (IDLE only):
  - Evaluated at the clock edge.
  - Data has fixed priority over fetch.
  - A port whose valid output is high in the current cycle is not eligible.
  - A fetch is not eligible while if_flush=1.
- On grant:
  - Register addr/we/wdata into mem_*.
  - Next state is BUSY_D or BUSY_I.
  - Counter = MEM_LATENCY.
  - mem_valid=1 for exactly the first BUSY cycle.
  - Fetch grants always issue mem_we=0.
- BUSY states: the counter decrements each cycle. At the edge ending the cycle where counter==1:
  - Capture mem_rdata into the granted port's rdata register. Stores leave d_rdata unchanged.
  - Pulse that port's valid for the next cycle.
  - Return to IDLE.
- Latency: request seen in IDLE at edge t → mem_valid in cycle t..t+1 → valid pulse in cycle starting at edge t+MEM_LATENCY. Total occupancy is MEM_LATENCY cycles, plus one valid cycle that overlaps IDLE.
- Stalls (combinational):
  - if_stall = if_req & ~if_valid
  - d_stall = d_req & ~d_valid
- if_flush:
  - In BUSY_I, set a cancel flag. The memory access still completes (no abort), but the if_valid pulse is suppressed and the flag clears on return to IDLE.
  - if_flush in IDLE only blocks the grant that cycle.
  - Flush never affects data transactions.
- Simultaneous if_req and d_req in IDLE: grant data; fetch waits and is granted in the next IDLE cycle if still requested.
- A requester changing addr/we/wdata mid-transaction has no effect; values were latched at grant.
- Asynchronous reset mid-transaction: return immediately to reset values. The outstanding memory response is discarded and no valid pulse is produced.
- Idle with no requests: all strobes stay 0; mem_addr/mem_wdata hold their last values.

Test Plan:
- Reset, then if_req=1, if_addr=0x100, memory returns 0x00500093 → mem_valid pulses 1 cycle with mem_addr=0x100, mem_we=0; if_valid=1, if_rdata=0x00500093 exactly 4 cycles after grant; if_stall high until then.
- Same-cycle if_req (0x104) and d_req load (0x2000, returns 0xDEADBEEF) → data granted first, d_valid with 0xDEADBEEF at +4; fetch granted next idle cycle, if_valid at +9 from start.
- Store d_we=1, d_addr=0x2004, d_wdata=0x12345678 → mem_we=1, mem_wdata=0x12345678 for one cycle; d_valid pulses at +4; d_rdata unchanged.
- Fetch granted, if_flush=1 at BUSY cycle 2 → no if_valid; FSM IDLE after 4 cycles; new fetch 0x200 then completes normally.
- Assert reset in cycle 2 of a data load → all outputs 0 immediately; no d_valid after reset release; next request behaves as from reset.
- Held request after valid: d_req stays 1 during the d_valid cycle → no duplicate grant that cycle; one memory issue per transaction.
